// File: rtl/dp_pipe3.sv
// dp_pipe3: three-stage (IF -> EX -> WB) RV32I datapath driven by an external combinational control unit.
// Latency: fetch in cycle n, execute n+1, write back and retire n+2; one instruction per cycle without hazards.
// Backpressure: WB dmem wait (!dmem_ready) freezes every stage; imem_valid low bubbles IF/EX; RAW interlock without forwarding.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   PCsrc..alu_ctrl        control for the instruction currently in EX
//   opcode/funct3/funct7   EX instruction fields for the control unit; zero/less are the EX ALU flags
//   imem_*                 fetch port: imem_addr = pc_f, imem_rdata qualified by imem_valid
//   dmem_*                 WB data port: strobes held until dmem_ready, lane-aligned wdata and byte enables
//   stall, retire, misalign status pulses
//
// Build option: define DP_FWD_EN for WB->EX forwarding; otherwise a WB->EX RAW match interlocks one cycle.
//
// Encodings expected from the control unit:
//   Immsrc   000 I, 001 S, 010 B, 011 U, 100 J
//   alu_ctrl 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 pass-B
//   st_src / ld_src 00 word, 01 half, 10 byte;  u=1 zero-extends loads
//   target_sel 00 rs1+imm (JALR, LSB cleared), 01 pc+imm, 10/11 0+imm (LUI via Ressrc 11)
//   less is the unsigned compare when alu_ctrl is sltu, else signed
module dp_pipe3 #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          NREGS     = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCsrc,
   input  logic        MemWrite,
   input  logic        ALU_src,
   input  logic        RegWrite,
   input  logic        u,
   input  logic [2:0]  Immsrc,
   input  logic [1:0]  Ressrc,
   input  logic [1:0]  st_src,
   input  logic [1:0]  ld_src,
   input  logic [1:0]  target_sel,
   input  logic [3:0]  alu_ctrl,
   output logic [6:0]  opcode,
   output logic [6:0]  funct7,
   output logic [2:0]  funct3,
   output logic        zero,
   output logic        less,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   output logic        dmem_we,
   output logic        dmem_re,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        stall,
   output logic        retire,
   output logic        misalign
);

   localparam int AW = $clog2(NREGS);

   typedef struct packed {
      logic        vld;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } ifex_t;

   typedef struct packed {
      logic        vld;
      logic [31:0] alu;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic [31:0] target;
      logic [1:0]  ressrc;
      logic        memwrite;
      logic        regwrite;
      logic [1:0]  st_src;
      logic [1:0]  ld_src;
      logic        u;
   } exwb_t;

   localparam ifex_t IFEX_BUBBLE = '{vld: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};
   // All-zero WB contents match a NOP (addi x0): no write, no memory access.
   localparam exwb_t EXWB_BUBBLE = '0;

   logic [31:0] pc_f;
   ifex_t       ifex;
   exwb_t       exwb, exwb_n;
   logic [31:0] rf [NREGS];

   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [31:0] imm, rf_rs1, rf_rs2, rs1_val, rs2_val, alu_b, alu_res, target;
   logic        less_s, less_u, ex_pcsrc;
   logic        hit1, hit2, raw_stall, mem_wait, wb_we;
   logic [31:0] wb_result, load_val;
   logic [1:0]  wb_size;
   logic        is_load, mem_op, mis;

   // ---------------- EX: decode and register read ----------------
   assign opcode = ifex.instr[6:0];
   assign ex_rd  = ifex.instr[11:7];
   assign funct3 = ifex.instr[14:12];
   assign ex_rs1 = ifex.instr[19:15];
   assign ex_rs2 = ifex.instr[24:20];
   assign funct7 = ifex.instr[31:25];

   always_comb begin
      imm = {{20{ifex.instr[31]}}, ifex.instr[31:20]};
      case (Immsrc)
         3'b001:  imm = {{20{ifex.instr[31]}}, ifex.instr[31:25], ifex.instr[11:7]};
         3'b010:  imm = {{19{ifex.instr[31]}}, ifex.instr[31], ifex.instr[7],
                         ifex.instr[30:25], ifex.instr[11:8], 1'b0};
         3'b011:  imm = {ifex.instr[31:12], 12'h000};
         3'b100:  imm = {{11{ifex.instr[31]}}, ifex.instr[31], ifex.instr[19:12],
                         ifex.instr[20], ifex.instr[30:21], 1'b0};
         default: imm = {{20{ifex.instr[31]}}, ifex.instr[31:20]};
      endcase
   end

   // Read in the WB-write cycle sees the old value; forwarding or the interlock covers it.
   assign rf_rs1 = (ex_rs1 == 5'd0) ? 32'h0 : rf[ex_rs1[AW-1:0]];
   assign rf_rs2 = (ex_rs2 == 5'd0) ? 32'h0 : rf[ex_rs2[AW-1:0]];

   assign wb_we = exwb.vld & exwb.regwrite & (exwb.rd != 5'd0);
   assign hit1  = wb_we & (exwb.rd == ex_rs1);
   assign hit2  = wb_we & (exwb.rd == ex_rs2);

`ifdef DP_FWD_EN
   assign rs1_val   = hit1 ? wb_result : rf_rs1;
   assign rs2_val   = hit2 ? wb_result : rf_rs2;
   assign raw_stall = 1'b0;
`else
   // rs2 is compared even when the field holds immediate bits: a spare stall is harmless.
   assign rs1_val   = rf_rs1;
   assign rs2_val   = rf_rs2;
   assign raw_stall = ifex.vld & (hit1 | hit2);
`endif

   // ---------------- EX: ALU and branch target ----------------
   assign alu_b  = ALU_src ? imm : rs2_val;
   assign less_s = $signed(rs1_val) < $signed(alu_b);
   assign less_u = rs1_val < alu_b;

   always_comb begin
      case (alu_ctrl)
         4'd1:    alu_res = rs1_val - alu_b;
         4'd2:    alu_res = rs1_val & alu_b;
         4'd3:    alu_res = rs1_val | alu_b;
         4'd4:    alu_res = rs1_val ^ alu_b;
         4'd5:    alu_res = rs1_val << alu_b[4:0];
         4'd6:    alu_res = rs1_val >> alu_b[4:0];
         4'd7:    alu_res = 32'($signed(rs1_val) >>> alu_b[4:0]);
         4'd8:    alu_res = {31'h0, less_s};
         4'd9:    alu_res = {31'h0, less_u};
         4'd10:   alu_res = alu_b;
         default: alu_res = rs1_val + alu_b;
      endcase
   end

   assign zero = (alu_res == 32'h0);
   assign less = (alu_ctrl == 4'd9) ? less_u : less_s;

   always_comb begin
      case (target_sel)
         2'b00:   target = (rs1_val + imm) & 32'hFFFF_FFFE;
         2'b01:   target = ifex.pc + imm;
         default: target = imm;
      endcase
   end

   assign ex_pcsrc = PCsrc & ifex.vld;

   always_comb begin
      exwb_n          = EXWB_BUBBLE;
      exwb_n.vld      = ifex.vld;
      exwb_n.alu      = alu_res;
      exwb_n.rs2      = rs2_val;
      exwb_n.rd       = ex_rd;
      exwb_n.pc4      = ifex.pc4;
      exwb_n.target   = target;
      exwb_n.ressrc   = Ressrc;
      exwb_n.memwrite = MemWrite & ifex.vld;
      exwb_n.regwrite = RegWrite & ifex.vld;
      exwb_n.st_src   = st_src;
      exwb_n.ld_src   = ld_src;
      exwb_n.u        = u;
   end

   // ---------------- WB: memory access and result select ----------------
   assign is_load = (exwb.ressrc == 2'b01) & ~exwb.memwrite;
   assign mem_op  = exwb.vld & (exwb.memwrite | is_load);
   assign wb_size = exwb.memwrite ? exwb.st_src : exwb.ld_src;
   assign mis     = ((wb_size == 2'b01) & exwb.alu[0]) |
                    (((wb_size == 2'b00) | (wb_size == 2'b11)) & (exwb.alu[1:0] != 2'b00));

   assign dmem_we   = exwb.vld & exwb.memwrite & ~mis;
   assign dmem_re   = exwb.vld & is_load & ~mis;
   assign dmem_addr = exwb.alu;
   assign misalign  = mem_op & mis;

   always_comb begin
      case (exwb.st_src)
         2'b01: begin
            dmem_wdata = {2{exwb.rs2[15:0]}};
            dmem_be    = 4'b0011 << {exwb.alu[1], 1'b0};
         end
         2'b10: begin
            dmem_wdata = {4{exwb.rs2[7:0]}};
            dmem_be    = 4'b0001 << exwb.alu[1:0];
         end
         default: begin
            dmem_wdata = exwb.rs2;
            dmem_be    = 4'b1111;
         end
      endcase
      // Loads use the lane of their own size.
      if (!exwb.memwrite) begin
         case (exwb.ld_src)
            2'b01:   dmem_be = 4'b0011 << {exwb.alu[1], 1'b0};
            2'b10:   dmem_be = 4'b0001 << exwb.alu[1:0];
            default: dmem_be = 4'b1111;
         endcase
      end
      if (!(dmem_we | dmem_re))
         dmem_be = 4'b0000;
   end

   always_comb begin
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      lane_b = 8'(dmem_rdata >> {exwb.alu[1:0], 3'b000});
      lane_h = exwb.alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (exwb.ld_src)
         2'b01:   load_val = exwb.u ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
         2'b10:   load_val = exwb.u ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
         default: load_val = dmem_rdata;
      endcase
      // A misaligned load still retires but writes zero.
      if (mis)
         load_val = 32'h0;
   end

   always_comb begin
      case (exwb.ressrc)
         2'b01:   wb_result = load_val;
         2'b10:   wb_result = exwb.pc4;
         2'b11:   wb_result = exwb.target;
         default: wb_result = exwb.alu;
      endcase
   end

   assign mem_wait  = (dmem_we | dmem_re) & ~dmem_ready;
   assign stall     = mem_wait | raw_stall;
   assign retire    = exwb.vld & ~mem_wait;
   assign imem_addr = pc_f;

   // ---------------- State ----------------
   // Priority: memory wait freezes all; RAW interlock holds PC/IF-EX; redirect beats a missing fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_f <= RESET_PC;
         ifex <= IFEX_BUBBLE;
         exwb <= EXWB_BUBBLE;
      end else if (!mem_wait) begin
         exwb <= raw_stall ? EXWB_BUBBLE : exwb_n;
         if (raw_stall) begin
            pc_f <= pc_f;
            ifex <= ifex;
         end else if (ex_pcsrc) begin
            pc_f <= target;
            ifex <= IFEX_BUBBLE;
         end else if (imem_valid) begin
            pc_f <= pc_f + 32'd4;
            ifex <= '{vld: 1'b1, instr: imem_rdata, pc: pc_f, pc4: pc_f + 32'd4};
         end else begin
            ifex <= IFEX_BUBBLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            rf[i] <= 32'h0;
      end else if (wb_we && !mem_wait) begin
         rf[exwb.rd[AW-1:0]] <= wb_result;
      end
   end

endmodule

// File: tb/tb_dp_pipe3.sv
// tb_dp_pipe3: self-checking bench for dp_pipe3 with a small control decoder and memory models.
// Latency: expected dmem writes are queued when a program is loaded and popped as the DUT writes.
// Backpressure: dmem_ready and imem_valid are driven by the bench to exercise freezes and bubbles.
module tb_dp_pipe3;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef DP_FWD_EN
   localparam int EXP_STALL = 0;
`else
   localparam int EXP_STALL = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        PCsrc, MemWrite, ALU_src, RegWrite, u;
   logic [2:0]  Immsrc;
   logic [1:0]  Ressrc, st_src, ld_src, target_sel;
   logic [3:0]  alu_ctrl;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic        zero, less;
   logic [31:0] imem_addr, imem_rdata;
   logic        imem_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        dmem_we, dmem_re, dmem_ready;
   logic        stall, retire, misalign;

   always #5 clk = ~clk;

   dp_pipe3 dut (
      .clk(clk), .reset(reset),
      .PCsrc(PCsrc), .MemWrite(MemWrite), .ALU_src(ALU_src), .RegWrite(RegWrite), .u(u),
      .Immsrc(Immsrc), .Ressrc(Ressrc), .st_src(st_src), .ld_src(ld_src),
      .target_sel(target_sel), .alu_ctrl(alu_ctrl),
      .opcode(opcode), .funct7(funct7), .funct3(funct3), .zero(zero), .less(less),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .stall(stall), .retire(retire), .misalign(misalign)
   );

   // Minimal control unit: addi, add/sub, beq/bne/blt, sb/sh/sw, lb/lh/lw/lbu/lhu.
   always_comb begin
      PCsrc = 1'b0; MemWrite = 1'b0; ALU_src = 1'b0; RegWrite = 1'b0; u = 1'b0;
      Immsrc = 3'b000; Ressrc = 2'b00; st_src = 2'b00; ld_src = 2'b00;
      target_sel = 2'b01; alu_ctrl = 4'd0;
      case (opcode)
         7'b0010011: begin RegWrite = 1'b1; ALU_src = 1'b1; end
         7'b0110011: begin
            RegWrite = 1'b1;
            alu_ctrl = (funct7 == 7'b0100000) ? 4'd1 : 4'd0;
         end
         7'b1100011: begin
            Immsrc = 3'b010; alu_ctrl = 4'd1;
            PCsrc  = (funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? !zero :
                     (funct3 == 3'b100) ? less : 1'b0;
         end
         7'b0100011: begin
            MemWrite = 1'b1; ALU_src = 1'b1; Immsrc = 3'b001;
            st_src = (funct3 == 3'b000) ? 2'b10 : (funct3 == 3'b001) ? 2'b01 : 2'b00;
         end
         7'b0000011: begin
            RegWrite = 1'b1; ALU_src = 1'b1; Ressrc = 2'b01; u = funct3[2];
            ld_src = (funct3[1:0] == 2'b00) ? 2'b10 : (funct3[1:0] == 2'b01) ? 2'b01 : 2'b00;
         end
         default: ;
      endcase
   end

   // Memories
   logic [31:0] imem [64];
   logic [31:0] dmem [256];
   assign imem_rdata = imem[imem_addr[7:2]];
   assign dmem_rdata = dmem[dmem_addr[9:2]];

   always @(posedge clk) begin
      if (!reset && dmem_we && dmem_ready)
         for (int b = 0; b < 4; b++)
            if (dmem_be[b]) dmem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
   end

   // Instruction encoders
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
      return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
   endfunction
   function automatic logic [31:0] load(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [11:0] imm);
      return enc_i(imm, 5'd0, f3, rd, 7'b0000011);
   endfunction
   function automatic logic [31:0] store(input logic [2:0] f3, input logic [4:0] rs2,
                                         input logic [11:0] imm);
      return {imm[11:5], rs2, 5'd0, f3, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [12:0] off);
      return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
   endfunction

   // Scoreboard and counters
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];
   int  n_checks = 0, n_err = 0;
   int  stall_cnt = 0, mis_cnt = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (!reset) begin
         if (stall) stall_cnt++;
         if (dmem_we && dmem_ready) begin
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               wr_t w;
               w = exp_q.pop_front();
               check("wr_addr", dmem_addr, w.addr);
               check("wr_be", 32'(dmem_be), 32'(w.be));
               check("wr_data", dmem_wdata, w.data);
            end
         end
         if (misalign) begin
            mis_cnt++;
            check("mis_re", 32'(dmem_re), 32'd0);
            check("mis_we", 32'(dmem_we), 32'd0);
            check("mis_retire", 32'(retire), 32'd1);
         end
      end
   end

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = NOP;
   endtask

   // Holds reset for two cycles and releases it on a falling edge.
   task automatic boot();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      stall_cnt = 0;
      mis_cnt   = 0;
      reset     = 1'b0;
   endtask

   task automatic wait_we(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); #1;
         if (dmem_we) begin ok = 1'b1; break; end
      end
   endtask

   task automatic drain(input string tag);
      repeat (12) @(negedge clk);
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      bit          ok;
      logic [31:0] held_pc;

      reset = 1'b1; imem_valid = 1'b1; dmem_ready = 1'b1;
      for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
      clear_imem();
      @(negedge clk); #1;
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_retire", 32'(retire), 32'd0);
      check("rst_misalign", 32'(misalign), 32'd0);
      check("rst_we", 32'(dmem_we), 32'd0);
      check("rst_re", 32'(dmem_re), 32'd0);
      check("rst_be", 32'(dmem_be), 32'd0);

      // Test 1: reset mid-access drops the store; then RAW pair addi/add gives x2=10.
      imem[0] = addi(5'd1, 5'd0, 12'd5);
      imem[1] = add(5'd2, 5'd1, 5'd1);
      imem[3] = store(3'b010, 5'd2, 12'h020);
      dmem_ready = 1'b0;
      boot();
      wait_we(ok);
      check("t1_we_seen", 32'(ok), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("t1_rst_drops_we", 32'(dmem_we), 32'd0);
      check("t1_rst_retire", 32'(retire), 32'd0);
      dmem_ready = 1'b1;
      exp_q.push_back('{addr: 32'h20, be: 4'hF, data: 32'd10});
      boot();
      #1;
      check("t1_c1_imem_addr", imem_addr, 32'h0);
      check("t1_c1_retire", 32'(retire), 32'd0);
      check("t1_c1_we", 32'(dmem_we), 32'd0);
      @(negedge clk); #1;
      check("t1_c2_retire", 32'(retire), 32'd0);
      check("t1_c2_re", 32'(dmem_re), 32'd0);
      @(negedge clk); #1;
      check("t1_c3_retire", 32'(retire), 32'd1);
      drain("t1_drain");
      check("t1_stall_cycles", 32'(stall_cnt), 32'(EXP_STALL));

      // Test 2: taken beq at 0x10 skips 0x14.
      clear_imem();
      imem[4] = beq(5'd0, 5'd0, 13'd8);
      imem[5] = addi(5'd7, 5'd0, 12'h077);
      imem[6] = store(3'b010, 5'd7, 12'h030);
      exp_q.push_back('{addr: 32'h30, be: 4'hF, data: 32'h0});
      boot();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (imem_addr == 32'h14) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("t2_reach_0x14", 32'(ok), 32'd1);
      @(negedge clk); #1;
      check("t2_next_fetch", imem_addr, 32'h18);
      @(negedge clk); #1;
      check("t2_bubble_no_retire", 32'(retire), 32'd0);
      drain("t2_drain");

      // Test 3: sb lane/replication, lb/lbu extension, load-use into stores, random fetch gaps.
      clear_imem();
      imem[0] = addi(5'd3, 5'd0, 12'h0AB);
      imem[2] = store(3'b000, 5'd3, 12'h103);
      imem[3] = load(3'b000, 5'd5, 12'h103);
      imem[4] = load(3'b100, 5'd6, 12'h103);
      imem[5] = store(3'b010, 5'd6, 12'h044);
      imem[6] = store(3'b010, 5'd5, 12'h040);
      exp_q.push_back('{addr: 32'h103, be: 4'b1000, data: 32'hABAB_ABAB});
      exp_q.push_back('{addr: 32'h44, be: 4'hF, data: 32'h0000_00AB});
      exp_q.push_back('{addr: 32'h40, be: 4'hF, data: 32'hFFFF_FFAB});
      boot();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         imem_valid = ($urandom_range(0, 3) != 0);
      end
      imem_valid = 1'b1;
      drain("t3_drain");

      // Test 4: misaligned lw writes 0 and retires without a dmem strobe.
      clear_imem();
      imem[0] = addi(5'd4, 5'd0, 12'd7);
      imem[2] = load(3'b010, 5'd4, 12'h102);
      imem[4] = store(3'b010, 5'd4, 12'h048);
      exp_q.push_back('{addr: 32'h48, be: 4'hF, data: 32'h0});
      boot();
      drain("t4_drain");
      check("t4_mis_pulses", 32'(mis_cnt), 32'd1);

      // Test 5: dmem_ready low for 3 cycles on sw holds everything; one write follows.
      clear_imem();
      imem[0] = addi(5'd1, 5'd0, 12'h055);
      imem[2] = store(3'b010, 5'd1, 12'h050);
      imem[3] = addi(5'd2, 5'd0, 12'd1);
      exp_q.push_back('{addr: 32'h50, be: 4'hF, data: 32'h55});
      dmem_ready = 1'b0;
      boot();
      wait_we(ok);
      check("t5_we_seen", 32'(ok), 32'd1);
      held_pc = imem_addr;
      for (int k = 0; k < 3; k++) begin
         if (k != 0) begin @(negedge clk); #1; end
         check("t5_hold_we", 32'(dmem_we), 32'd1);
         check("t5_hold_stall", 32'(stall), 32'd1);
         check("t5_hold_pc", imem_addr, held_pc);
         check("t5_hold_addr", dmem_addr, 32'h50);
         check("t5_hold_wdata", dmem_wdata, 32'h55);
         check("t5_hold_retire", 32'(retire), 32'd0);
      end
      @(negedge clk);
      dmem_ready = 1'b1;
      #1;
      check("t5_release_pc", imem_addr, held_pc);
      @(negedge clk); #1;
      check("t5_pc_advances", imem_addr, held_pc + 32'd4);
      drain("t5_drain");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
